// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_sdp_be_sc_param RAM family.
//   rdw_mode_e           - read-during-write policy selector
//   PARITY_BITS_PER_BYTE - extra stored bits per byte lane when parity is built in
//   bytes_of()           - number of byte lanes in a data word
//   byte_merge()         - per-byte merge of two words under a byte-enable mask
// byte_merge works on a fixed wide vector so one definition serves every
// DATA_WIDTH up to MERGE_W. Callers zero-extend the inputs and truncate the result.
package ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int PARITY_BITS_PER_BYTE = 1;
  localparam int MERGE_W              = 512;
  localparam int MERGE_BE_W           = MERGE_W / 8;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  // Bytes whose enable bit is set come from new_word; all others keep old_word.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_sdp_be_sc_param_if.sv
// ram_sdp_be_sc_param_if: write/read bus for the simple dual-port RAM.
//   we, be, waddr, din   - write port (per-byte enables)
//   re, raddr            - read request
//   dout, dout_valid     - read result and its one-cycle valid pulse
//   collision            - read hit the same-cycle write address
//   parity_err           - per-byte parity mismatch (only with RAM_BYTE_PARITY_EN)
// Modports: master drives requests, slave is the RAM.
interface ram_sdp_be_sc_param_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  localparam int NB = bytes_of(DATA_WIDTH);

  logic                  we;
  logic [NB-1:0]         be;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] din;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  collision;
`ifdef RAM_BYTE_PARITY_EN
  logic [NB-1:0]         parity_err;

  modport master (
    output we, be, waddr, din, re, raddr,
    input  dout, dout_valid, collision, parity_err
  );
  modport slave (
    input  we, be, waddr, din, re, raddr,
    output dout, dout_valid, collision, parity_err
  );
`else
  modport master (
    output we, be, waddr, din, re, raddr,
    input  dout, dout_valid, collision
  );
  modport slave (
    input  we, be, waddr, din, re, raddr,
    output dout, dout_valid, collision
  );
`endif

endinterface

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: read-result register chain of STAGES (1 or 2) stages.
//   clk, rst        - clock and synchronous active-high clear
//   in_valid        - a read result enters this cycle
//   in_data         - read word
//   in_collision    - that read collided with a same-cycle write
//   in_parity_err   - per-byte parity mismatch (RAM_BYTE_PARITY_EN only)
//   out_*           - last stage; data holds between results, flags pulse with out_valid
// Payload registers load only when a valid result moves in, so out_data keeps
// the last completed read while out_valid is low.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NB         = 4,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_collision,
`ifdef RAM_BYTE_PARITY_EN
  input  logic [NB-1:0]         in_parity_err,
  output logic [NB-1:0]         out_parity_err,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_collision
);
`ifdef RAM_BYTE_PARITY_EN
  localparam int PW = DATA_WIDTH + 1 + NB;
  logic [PW-1:0] in_payload;
  assign in_payload = {in_parity_err, in_collision, in_data};
`else
  localparam int PW = DATA_WIDTH + 1;
  logic [PW-1:0] in_payload;
  assign in_payload = {in_collision, in_data};
`endif

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic          prev_valid;
    logic [PW-1:0] prev_payload;
    logic          valid_reg;
    logic [PW-1:0] payload_reg;

    if (gi == 0) begin : g_first
      assign prev_valid   = in_valid;
      assign prev_payload = in_payload;
    end else begin : g_next
      assign prev_valid   = g_stage[gi-1].valid_reg;
      assign prev_payload = g_stage[gi-1].payload_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg   <= 1'b0;
        payload_reg <= '0;
      end else begin
        valid_reg <= prev_valid;
        if (prev_valid) payload_reg <= prev_payload;
      end
    end
  end

  assign out_valid     = g_stage[STAGES-1].valid_reg;
  assign out_data      = g_stage[STAGES-1].payload_reg[DATA_WIDTH-1:0];
  // Flags are only meaningful alongside a fresh result.
  assign out_collision = out_valid & g_stage[STAGES-1].payload_reg[DATA_WIDTH];
`ifdef RAM_BYTE_PARITY_EN
  assign out_parity_err = {NB{out_valid}} & g_stage[STAGES-1].payload_reg[PW-1 -: NB];
`endif

endmodule

// File: rtl/ram_sdp_be_sc_param.sv
// ram_sdp_be_sc_param: single-clock simple dual-port RAM with byte enables.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears read pipeline, blocks writes/reads)
//   bus  - ram_sdp_be_sc_param_if.slave: write port (we/be/waddr/din),
//          read port (re/raddr), results (dout/dout_valid/collision[/parity_err])
// Parameters: DATA_WIDTH (multiple of 8), DEPTH (any), RD_LATENCY (1 or 2),
//   RDW_MODE (0 = old data on same-cycle hit, 1 = byte-merged new data).
// Optional build macro RAM_BYTE_PARITY_EN adds an even-parity bit per stored
// byte and the parity_err output.
// Storage is one array per byte lane so each lane has its own write enable.
module ram_sdp_be_sc_param
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input logic                  clk,
  input logic                  rst,
  ram_sdp_be_sc_param_if.slave bus
);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB         = bytes_of(DATA_WIDTH);
`ifdef RAM_BYTE_PARITY_EN
  localparam int LANE_W     = 8 + PARITY_BITS_PER_BYTE;
`else
  localparam int LANE_W     = 8;
`endif
  localparam rdw_mode_e RDW = rdw_mode_e'(RDW_MODE[0]);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MERGE_W) begin : g_bad_width
    $error("ram_sdp_be_sc_param: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_be_sc_param: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("ram_sdp_be_sc_param: RDW_MODE must be 0 or 1");
  end

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic                  rd_collision;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [NB-1:0]         merge_be;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;
`ifdef RAM_BYTE_PARITY_EN
  logic [NB-1:0]         rd_perr;
`endif

  // Out-of-range addresses never touch the array; the index is parked at 0.
  assign wr_in_range = {1'b0, bus.waddr} < DEPTH_LIMIT;
  assign rd_in_range = {1'b0, bus.raddr} < DEPTH_LIMIT;
  assign wr_idx      = wr_in_range ? bus.waddr : '0;
  assign rd_idx      = rd_in_range ? bus.raddr : '0;

  assign wr_en        = bus.we & ~rst & wr_in_range;
  assign rd_en        = bus.re & ~rst;
  assign rd_collision = rd_en & bus.we & rd_in_range & (|bus.be) &
                        (bus.raddr == bus.waddr);

  // Bytes forwarded from din on a write-first hit; zero means pure old data.
  assign merge_be = ((RDW == RDW_WRITE_FIRST) && rd_collision) ? bus.be : '0;

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    logic [LANE_W-1:0] mem_lane [DEPTH];
    logic [LANE_W-1:0] wr_lane;
    logic [LANE_W-1:0] rd_lane;

`ifdef RAM_BYTE_PARITY_EN
    // Even parity: stored bit makes the 9-bit lane have an even number of ones.
    assign wr_lane = {^bus.din[8*gi +: 8], bus.din[8*gi +: 8]};
`else
    assign wr_lane = bus.din[8*gi +: 8];
`endif

    always_ff @(posedge clk) begin
      if (wr_en && bus.be[gi]) mem_lane[wr_idx] <= wr_lane;
    end

    // Array read returns pre-write contents this cycle; the first pipe stage
    // is the registered read.
    assign rd_lane = mem_lane[rd_idx];
    assign old_word[8*gi +: 8] = rd_lane[7:0];

`ifdef RAM_BYTE_PARITY_EN
    // A forwarded byte carries freshly computed parity, so it cannot mismatch.
    assign rd_perr[gi] = rd_in_range & ~merge_be[gi] &
                         (rd_lane[LANE_W-1] ^ (^rd_lane[7:0]));
`endif
  end

  assign rd_word = rd_in_range
                 ? DATA_WIDTH'(byte_merge(MERGE_W'(old_word), MERGE_W'(bus.din),
                                          MERGE_BE_W'(merge_be)))
                 : '0;

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB         (NB),
    .STAGES     ((RD_LATENCY == 2) ? 2 : 1)
  ) u_rd_pipe (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (rd_en),
    .in_data        (rd_word),
    .in_collision   (rd_collision),
`ifdef RAM_BYTE_PARITY_EN
    .in_parity_err  (rd_perr),
    .out_parity_err (bus.parity_err),
`endif
    .out_data       (bus.dout),
    .out_valid      (bus.dout_valid),
    .out_collision  (bus.collision)
  );

endmodule

// File: tb/tb_ram_sdp_be_sc_param.sv
// Bench for ram_sdp_be_sc_param. Two instances share one stimulus stream:
//   inst 0: DEPTH=512, RD_LATENCY=1, READ_FIRST
//   inst 1: DEPTH=300, RD_LATENCY=2, WRITE_FIRST
// A word-level model predicts every read result and the cycle it is due;
// a compare process checks both instances on every cycle, and directed steps
// pin hand-computed literal values.
module tb_ram_sdp_be_sc_param;
  import ram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          we_s = 1'b0;
  logic [3:0]    be_s = '0;
  logic [AW-1:0] waddr_s = '0;
  logic [DW-1:0] din_s = '0;
  logic          re_s = 1'b0;
  logic [AW-1:0] raddr_s = '0;

  ram_sdp_be_sc_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  ram_sdp_be_sc_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  assign ifa.we = we_s;   assign ifb.we = we_s;
  assign ifa.be = be_s;   assign ifb.be = be_s;
  assign ifa.waddr = waddr_s; assign ifb.waddr = waddr_s;
  assign ifa.din = din_s; assign ifb.din = din_s;
  assign ifa.re = re_s;   assign ifb.re = re_s;
  assign ifa.raddr = raddr_s; assign ifb.raddr = raddr_s;

  ram_sdp_be_sc_param #(.DATA_WIDTH(32), .DEPTH(512), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  ram_sdp_be_sc_param #(.DATA_WIDTH(32), .DEPTH(300), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // ---------------- model ----------------
  int          cyc = 0;
  logic [31:0] mdl_mem [NK][512];
  int          mdl_depth [NK] = '{512, 300};
  int          mdl_lat   [NK] = '{1, 2};
  bit          mdl_wf    [NK] = '{1'b0, 1'b1};
  bit          slot_v [NK][4];
  logic [31:0] slot_d [NK][4];
  bit          slot_c [NK][4];
  logic [31:0] last_dout [NK];
  logic [31:0] pushed_d [NK];
  bit          pushed_c [NK];
  int          vcount [NK];
  int          tests = 0;
  int          failed = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] fill_val(input int a);
    return {16'hC0DE ^ a[15:0], a[15:0]};
  endfunction

  // At each edge: a request (if any) is resolved against the memory as it was
  // before this edge's write, then the write is applied.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < NK; k++) begin
        if (rst) begin
          for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
          last_dout[k] = '0;
        end else begin
          if (re_s) begin
            bit          hit;
            logic [31:0] d;
            int          s;
            hit = we_s && (raddr_s == waddr_s) && (be_s != 4'h0) && (int'(raddr_s) < mdl_depth[k]);
            if (int'(raddr_s) >= mdl_depth[k]) d = '0;
            else if (hit && mdl_wf[k])
              d = 32'(byte_merge(MERGE_W'(mdl_mem[k][raddr_s]), MERGE_W'(din_s), MERGE_BE_W'(be_s)));
            else d = mdl_mem[k][raddr_s];
            s = (cyc + mdl_lat[k] - 1) % 4;
            slot_v[k][s] = 1'b1;
            slot_d[k][s] = d;
            slot_c[k][s] = hit;
            pushed_d[k] = d;
            pushed_c[k] = hit;
          end
          if (we_s && int'(waddr_s) < mdl_depth[k])
            mdl_mem[k][waddr_s] = 32'(byte_merge(MERGE_W'(mdl_mem[k][waddr_s]), MERGE_W'(din_s),
                                                 MERGE_BE_W'(be_s)));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int k = 0; k < NK; k++) begin
          logic [31:0] act_d;
          logic        act_v;
          logic        act_c;
          int          s;
          act_d = (k == 0) ? ifa.dout : ifb.dout;
          act_v = (k == 0) ? ifa.dout_valid : ifb.dout_valid;
          act_c = (k == 0) ? ifa.collision : ifb.collision;
          s = cyc % 4;
          chk("dout_valid", k, {31'b0, act_v}, {31'b0, slot_v[k][s]});
          if (slot_v[k][s]) begin
            chk("dout", k, act_d, slot_d[k][s]);
            chk("collision", k, {31'b0, act_c}, {31'b0, slot_c[k][s]});
            last_dout[k] = slot_d[k][s];
            vcount[k]++;
          end else begin
            chk("dout_hold", k, act_d, last_dout[k]);
            chk("collision_idle", k, {31'b0, act_c}, 32'h0);
          end
`ifdef RAM_BYTE_PARITY_EN
          chk("parity_err", k, {28'b0, ((k == 0) ? ifa.parity_err : ifb.parity_err)}, 32'h0);
`endif
          slot_v[k][s] = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input bit we, input logic [3:0] be, input logic [AW-1:0] wa,
                      input logic [31:0] d, input bit re, input logic [AW-1:0] ra);
    we_s = we; be_s = be; waddr_s = wa; din_s = d; re_s = re; raddr_s = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic lit(input string name, input int k, input logic [31:0] d, input bit v, input bit c);
    logic [31:0] act_d;
    logic        act_v;
    logic        act_c;
    act_d = (k == 0) ? ifa.dout : ifb.dout;
    act_v = (k == 0) ? ifa.dout_valid : ifb.dout_valid;
    act_c = (k == 0) ? ifa.collision : ifb.collision;
    $display("[TB] %s inst=%0d dout=%h valid=%0b collision=%0b", name, k, act_d, act_v, act_c);
    chk({name, "_dout"}, k, act_d, d);
    chk({name, "_valid"}, k, {31'b0, act_v}, {31'b0, v});
    chk({name, "_coll"}, k, {31'b0, act_c}, {31'b0, c});
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NK; k++) begin
      vcount[k] = 0;
      last_dout[k] = '0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    lit("reset_idle", 0, 32'h0, 1'b0, 1'b0);
    lit("reset_idle", 1, 32'h0, 1'b0, 1'b0);

    // Known contents everywhere before any read.
    for (int a = 0; a < 512; a++) step(1'b1, 4'hF, AW'(a), fill_val(a), 1'b0, '0);

    // Full write then read next cycle.
    step(1'b1, 4'hF, 9'h1FF, 32'hA5A5_0001, 1'b0, '0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'h1FF);
    chk("model_full_write", 0, pushed_d[0], 32'hA5A5_0001);
    lit("full_write_rd", 0, 32'hA5A5_0001, 1'b1, 1'b0);
    idle(1);
    lit("oob_1ff_rd", 1, 32'h0, 1'b1, 1'b0);

    // Partial write.
    step(1'b1, 4'hF, 9'd7, 32'h1122_3344, 1'b0, '0);
    step(1'b1, 4'b0101, 9'd7, 32'hFFFF_FFFF, 1'b0, '0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'd7);
    chk("model_partial", 0, pushed_d[0], 32'h11FF_33FF);
    lit("partial_rd", 0, 32'h11FF_33FF, 1'b1, 1'b0);
    idle(1);
    lit("partial_rd", 1, 32'h11FF_33FF, 1'b1, 1'b0);

    // Same-cycle collision.
    step(1'b1, 4'hF, 9'd7, 32'h1122_3344, 1'b0, '0);
    step(1'b1, 4'b0011, 9'd7, 32'hDEAD_BEEF, 1'b1, 9'd7);
    chk("model_rf", 0, pushed_d[0], 32'h1122_3344);
    chk("model_wf", 1, pushed_d[1], 32'h1122_BEEF);
    chk("model_coll", 1, {31'b0, pushed_c[1]}, 32'h1);
    lit("coll_read_first", 0, 32'h1122_3344, 1'b1, 1'b1);
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'd7);
    lit("coll_write_first", 1, 32'h1122_BEEF, 1'b1, 1'b1);
    lit("after_coll_rd", 0, 32'h1122_BEEF, 1'b1, 1'b0);
    idle(1);
    lit("after_coll_rd", 1, 32'h1122_BEEF, 1'b1, 1'b0);

    // we with be=0: no write, no collision.
    step(1'b1, 4'h0, 9'd7, 32'hFFFF_FFFF, 1'b1, 9'd7);
    lit("be_zero", 0, 32'h1122_BEEF, 1'b1, 1'b0);
    idle(2);

    // Out-of-range on the DEPTH=300 instance.
    step(1'b1, 4'hF, 9'd300, 32'h1234_5678, 1'b0, '0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'd300);
    lit("addr300_rd", 0, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'd299);
    lit("oob300_rd", 1, 32'h0, 1'b1, 1'b0);
    lit("addr299_rd", 0, fill_val(299), 1'b1, 1'b0);
    idle(1);
    lit("addr299_rd", 1, fill_val(299), 1'b1, 1'b0);
    step(1'b1, 4'hF, 9'd300, 32'h0BAD_F00D, 1'b1, 9'd300);
    lit("coll_300", 0, 32'h1234_5678, 1'b1, 1'b1);
    idle(1);
    lit("oob_no_coll", 1, 32'h0, 1'b1, 1'b0);
    idle(2);

    // Reset while a read is in flight in the 2-stage instance.
    step(1'b0, 4'h0, '0, '0, 1'b1, 9'd5);
    lit("pre_rst_rd", 0, fill_val(5), 1'b1, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      lit("dropped_rd", 1, 32'h0, 1'b0, 1'b0);
    end

    // Streaming reads with no bubbles.
    vcount[0] = 0;
    vcount[1] = 0;
    for (int a = 0; a < 512; a++) step(1'b0, 4'h0, '0, '0, 1'b1, AW'(a));
    idle(3);
    $display("[TB] stream valid pulses inst0=%0d inst1=%0d", vcount[0], vcount[1]);
    chk("stream_count", 0, 32'(vcount[0]), 32'd512);
    chk("stream_count", 1, 32'(vcount[1]), 32'd512);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
